// File: rtl/dwt_scale_line_arbiter.sv
// Line-atomic round-robin arbiter that shares one DWT scaling datapath
// between several stream sources. A grant is held from the first beat of
// a line until its eol beat is accepted, and every beat is tagged with the
// index of the source that owns it.
module dwt_scale_line_arbiter #(
    parameter  int DataWidth = 16,
    parameter  int NumReq    = 2,
    parameter  bit OutputReg = 1'b1,
    localparam int IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NumReq-1:0]           s_valid_i,
    output logic [NumReq-1:0]           s_ready_o,
    input  logic [NumReq-1:0]           s_sof_i,
    input  logic [NumReq-1:0]           s_eol_i,
    input  logic [NumReq*DataWidth-1:0] s_data_i,
    input  logic                        m_ready_i,
    output logic                        m_valid_o,
    output logic                        m_sof_o,
    output logic                        m_eol_o,
    output logic [DataWidth-1:0]        m_data_o,
    output logic [IdWidth-1:0]          m_id_o,
    output logic                        busy_o,
    output logic                        err_sof_o
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [IdWidth-1:0]   grant_q;
    logic [IdWidth-1:0]   last_ptr_q;
    logic                 first_beat_q;
    logic                 err_sof_q;

    logic                 rr_found;
    logic [IdWidth-1:0]   rr_idx;
    logic                 locked;
    logic                 dn_accept;
    logic                 xfer;
    logic                 g_valid;
    logic                 g_sof;
    logic                 g_eol;
    logic [DataWidth-1:0] g_data;

    assign locked  = (state_q == ST_LOCKED);
    assign g_valid = s_valid_i[grant_q];
    assign g_sof   = s_sof_i[grant_q];
    assign g_eol   = s_eol_i[grant_q];
    assign g_data  = s_data_i[int'(grant_q)*DataWidth +: DataWidth];
    assign xfer    = locked && g_valid && dn_accept;

    // Round-robin search: first valid source strictly after last_ptr.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        rr_found = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        for (int k = 1; k <= NumReq; k++) begin
            idx = (int'(last_ptr_q) + k) % NumReq;
            if (!rr_found && s_valid_i[idx]) begin
                rr_found = 1'b1;
                rr_idx   = IdWidth'(idx);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: arbitrate while idle, release the grant on an accepted eol.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rr_found) state_d = ST_LOCKED;
            ST_LOCKED: if (xfer && g_eol) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Grant, round-robin pointer, first-beat tracking and sof error pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q      <= '0;
            last_ptr_q   <= IdWidth'(NumReq - 1);
            first_beat_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            err_sof_q <= xfer && g_sof && !first_beat_q;
            if (!locked && rr_found) begin
                grant_q      <= rr_idx;
                first_beat_q <= 1'b1;
            end else if (xfer) begin
                first_beat_q <= 1'b0;
                if (g_eol) last_ptr_q <= grant_q;
            end
        end
    end

    // Only the granted source may see ready, and only while locked.
    always_comb begin
        s_ready_o = '0;
        if (locked) s_ready_o[grant_q] = dn_accept;
    end

    assign busy_o    = locked;
    assign err_sof_o = err_sof_q;

    generate
        if (OutputReg) begin : g_out_reg
            logic                 out_valid_q;
            logic                 out_sof_q;
            logic                 out_eol_q;
            logic [DataWidth-1:0] out_data_q;
            logic [IdWidth-1:0]   out_id_q;

            assign dn_accept = !out_valid_q || m_ready_i;

            // Single-entry skid-free output register: loads on transfer, drains on m_ready.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    // NOTE: the payload is reset too, so a mid-line reset leaves every output at 0.
                    out_valid_q <= 1'b0;
                    out_sof_q   <= 1'b0;
                    out_eol_q   <= 1'b0;
                    out_data_q  <= '0;
                    out_id_q    <= '0;
                end else if (xfer) begin
                    out_valid_q <= 1'b1;
                    out_sof_q   <= g_sof;
                    out_eol_q   <= g_eol;
                    out_data_q  <= g_data;
                    out_id_q    <= grant_q;
                end else if (m_ready_i) begin
                    out_valid_q <= 1'b0;
                end
            end

            assign m_valid_o = out_valid_q;
            assign m_sof_o   = out_sof_q;
            assign m_eol_o   = out_eol_q;
            assign m_data_o  = out_data_q;
            assign m_id_o    = out_id_q;
        end else begin : g_out_comb
            assign dn_accept = m_ready_i;
            assign m_valid_o = locked && g_valid;
            assign m_sof_o   = locked && g_sof;
            assign m_eol_o   = locked && g_eol;
            assign m_data_o  = locked ? g_data : '0;
            assign m_id_o    = locked ? grant_q : '0;
        end
    endgenerate

endmodule
